// File: rtl/dg0045_call_stack.sv
// Hardware return-address stack: DEPTH shift-register entries with entry[0]
// as the visible top, a registered fill level, and sticky overflow/underflow.
//
// Ports:
//   clk_in     clock, all state updates on posedge
//   RESET      asynchronous active-low reset
//   push       store push_data as the new top
//   pop        remove the top entry
//   flush      synchronously empty the stack (flags untouched)
//   clr_flags  clear sticky ovf/unf (a same-cycle set wins)
//   push_data  return address to push
//   top        entry[0]
//   level      number of valid entries, 0..DEPTH
//   empty      level == 0
//   full       level == DEPTH
//   ovf        sticky overflow flag
//   unf        sticky underflow flag
module dg0045_call_stack #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DEPTH    = 5,
  parameter int unsigned OVF_MODE = 0
) (
  input  logic          clk_in,
  input  logic          RESET,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          clr_flags,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [4:0]    level,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int unsigned LW = 5;

  logic [AW-1:0] entry_q [DEPTH];
  logic [AW-1:0] entry_d [DEPTH];
  logic [LW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q,  full_d;
  logic          ovf_q,   ovf_d;
  logic          unf_q,   unf_d;
  logic          is_full;

  assign is_full = (level_q == LW'(DEPTH));

  // Next-state: flush > push&pop > push > pop > hold; flag sets follow clears.
  always_comb begin
    entry_d = entry_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    if (clr_flags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_d[i] = '0;
      end
      level_d = '0;
    end else if (push && pop) begin
      // Replace the top in place: depth and flags are untouched.
      entry_d[0] = push_data;
    end else if (push) begin
      if (is_full && (OVF_MODE != 0)) begin
        ovf_d = 1'b1;
      end else begin
        for (int unsigned i = 1; i < DEPTH; i++) begin
          entry_d[i] = entry_q[i-1];
        end
        entry_d[0] = push_data;
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          level_d = level_q + LW'(1);
        end
      end
    end else if (pop) begin
      // Bottom entry is replicated upward, even when already empty.
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i+1];
      end
      if (level_q == '0) begin
        unf_d = 1'b1;
      end else begin
        level_d = level_q - LW'(1);
      end
    end

    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(DEPTH));
  end

  // State registers.
  always_ff @(posedge clk_in or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign top   = entry_q[0];
  assign level = level_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_dg0045_call_stack.sv
// Scoreboard bench: two stacks (discard-oldest and reject-when-full) share the
// same stimulus; expectations are queued by the driver and checked by a monitor.
module tb_dg0045_call_stack;

  logic       clk_in = 1'b0;
  logic       RESET;
  logic       push, pop, flush, clr_flags;
  logic [9:0] push_data;

  logic [9:0] top0, top1;
  logic [4:0] level0, level1;
  logic       empty0, empty1, full0, full1, ovf0, ovf1, unf0, unf1;

  always #5 clk_in = ~clk_in;

  dg0045_call_stack #(.AW(10), .DEPTH(5), .OVF_MODE(0)) u_dut0 (
    .clk_in(clk_in), .RESET(RESET), .push(push), .pop(pop), .flush(flush),
    .clr_flags(clr_flags), .push_data(push_data), .top(top0), .level(level0),
    .empty(empty0), .full(full0), .ovf(ovf0), .unf(unf0)
  );

  dg0045_call_stack #(.AW(10), .DEPTH(5), .OVF_MODE(1)) u_dut1 (
    .clk_in(clk_in), .RESET(RESET), .push(push), .pop(pop), .flush(flush),
    .clr_flags(clr_flags), .push_data(push_data), .top(top1), .level(level1),
    .empty(empty1), .full(full1), .ovf(ovf1), .unf(unf1)
  );

  typedef struct {
    string      name;
    int         which;
    logic [9:0] top;
    logic [4:0] level;
    logic       empty, full, ovf, unf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event mon_ev;

  task automatic chk(input string nm, input int w, input logic [9:0] t, input int lv,
                     input bit e, input bit f, input bit o, input bit u);
    exp_t x;
    x.name = nm; x.which = w; x.top = t; x.level = 5'(lv);
    x.empty = e; x.full = f; x.ovf = o; x.unf = u;
    q.push_back(x);
  endtask

  task automatic step(input bit pu, input bit po, input bit fl, input bit cl,
                      input logic [9:0] d);
    @(negedge clk_in);
    push = pu; pop = po; flush = fl; clr_flags = cl; push_data = d;
    @(posedge clk_in);
  endtask

  // Monitor: compares every queued expectation at the next sample point.
  initial begin
    forever begin
      @(negedge clk_in or mon_ev);
      while (q.size() > 0) begin
        exp_t x;
        logic [18:0] act, req;
        x = q.pop_front();
        if (x.which == 0) act = {top0, level0, empty0, full0, ovf0, unf0};
        else              act = {top1, level1, empty1, full1, ovf1, unf1};
        req = {x.top, x.level, x.empty, x.full, x.ovf, x.unf};
        n_checks++;
        if (act !== req) begin
          n_fail++;
          $display("FAIL %s dut%0d: got top=%h lvl=%0d e=%b f=%b o=%b u=%b, want top=%h lvl=%0d e=%b f=%b o=%b u=%b",
                   x.name, x.which, act[18:9], act[8:4], act[3], act[2], act[1], act[0],
                   req[18:9], req[8:4], req[3], req[2], req[1], req[0]);
        end
      end
    end
  end

  int e0 [5] = '{'h005, 'h004, 'h003, 'h002, 'h002};
  int e1 [5] = '{'h004, 'h003, 'h002, 'h001, 'h001};

  initial begin
    RESET = 1'b0; push = 0; pop = 0; flush = 0; clr_flags = 0; push_data = '0;
    repeat (2) @(negedge clk_in);
    chk("reset", 0, 'h000, 0, 1, 0, 0, 0);
    chk("reset", 1, 'h000, 0, 1, 0, 0, 0);
    @(negedge clk_in);
    RESET = 1'b1;

    // Three pushes
    step(1, 0, 0, 0, 'h011); chk("push1", 0, 'h011, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 'h022);
    step(1, 0, 0, 0, 'h033);
    chk("push3", 0, 'h033, 3, 0, 0, 0, 0);
    chk("push3", 1, 'h033, 3, 0, 0, 0, 0);

    // Asynchronous reset between edges
    step(0, 0, 0, 0, '0);
    @(negedge clk_in);
    @(posedge clk_in);
    #2 RESET = 1'b0;
    #1;
    chk("async_rst", 0, 'h000, 0, 1, 0, 0, 0);
    chk("async_rst", 1, 'h000, 0, 1, 0, 0, 0);
    -> mon_ev;
    @(negedge clk_in);
    RESET = 1'b1;

    // Overflow in both modes
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 0, 10'(i));
      if (i == 5) chk("fill5", 0, 'h005, 5, 0, 1, 0, 0);
    end
    chk("ovf_discard", 0, 'h006, 5, 0, 1, 1, 0);
    chk("ovf_reject",  1, 'h005, 5, 0, 1, 1, 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, '0);
      chk("pop_seq", 0, 10'(e0[i]), 4 - i, (i == 4), 0, 1, 0);
      chk("pop_seq", 1, 10'(e1[i]), 4 - i, (i == 4), 0, 1, 0);
    end

    // Flag clear, and underflow winning over clear
    step(0, 0, 0, 1, '0);  chk("clr", 0, 'h002, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, '0);  chk("set_wins", 0, 'h002, 0, 1, 0, 0, 1);
                           chk("set_wins", 1, 'h001, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, '0);  chk("clr_unf", 0, 'h002, 0, 1, 0, 0, 0);

    // Underflow replicates the bottom entry
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 'h3FF);
    chk("fill3ff", 0, 'h3FF, 5, 0, 1, 0, 0);
    chk("fill3ff", 1, 'h3FF, 5, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, '0);
    chk("drain3ff", 0, 'h3FF, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, '0);  chk("unf_bottom", 0, 'h3FF, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, '0);  chk("unf_clr", 0, 'h3FF, 0, 1, 0, 0, 0);

    // Flush, push&pop, flush priority
    step(0, 0, 1, 0, '0);      chk("flush", 0, 'h000, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 'h050);
    step(1, 0, 0, 0, 'h100);   chk("lvl2", 0, 'h100, 2, 0, 0, 0, 0);
    step(1, 1, 0, 0, 'h200);   chk("pushpop", 0, 'h200, 2, 0, 0, 0, 0);
                               chk("pushpop", 1, 'h200, 2, 0, 0, 0, 0);
    step(0, 1, 0, 0, '0);      chk("pp_keep", 0, 'h050, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 'h100);
    step(1, 0, 1, 0, 'h123);   chk("flush_push", 0, 'h000, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 'h077);   chk("pp_empty", 0, 'h077, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, '0);      chk("unf_zero", 0, 'h000, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, '0);      chk("flush_flag", 0, 'h000, 0, 1, 0, 0, 1);
    step(0, 0, 0, 1, '0);      chk("clr2", 0, 'h000, 0, 1, 0, 0, 0);

    // Push&pop when full, then overflow with simultaneous clear
    for (int i = 1; i <= 5; i++) step(1, 0, 0, 0, 10'('h0A0 + i));
    step(1, 1, 0, 0, 'h0BB);   chk("pp_full", 0, 'h0BB, 5, 0, 1, 0, 0);
                               chk("pp_full", 1, 'h0BB, 5, 0, 1, 0, 0);
    step(0, 1, 0, 0, '0);      chk("pop_after_pp", 0, 'h0A4, 4, 0, 0, 0, 0);
    step(1, 0, 0, 0, 'h0C1);   chk("refill", 0, 'h0C1, 5, 0, 1, 0, 0);
    step(1, 0, 0, 1, 'h0C2);   chk("ovf_vs_clr", 0, 'h0C2, 5, 0, 1, 1, 0);
                               chk("ovf_vs_clr", 1, 'h0C1, 5, 0, 1, 1, 0);
    step(0, 0, 0, 0, '0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_in);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
